// File: rtl/phasecalc_arbiter_pkg.sv
// Shared widths, angle constants, FSM encoding and pointer helper for the phasecalc arbiter.
package phasecalc_arbiter_pkg;

  localparam int XW_DEF      = 13;
  localparam int AW_DEF      = 19;
  localparam int FRAC        = 10;
  localparam int PI_Q10      = 3217;
  localparam int HALF_PI_Q10 = 1608;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/phasecalc_arbiter_rr.sv
// Combinational round-robin pick: first requesting channel at or after ptr, wrapping.
module phasecalc_arbiter_rr
  import phasecalc_arbiter_pkg::*;
#(
  parameter int NCH = 2,
  parameter int CW  = 1
) (
  input  logic [NCH-1:0] req,
  input  logic [CW-1:0]  ptr,
  output logic [NCH-1:0] grant,
  output logic [CW-1:0]  idx,
  output logic           any
);

  logic [CW-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    // Scan farthest-first so the channel closest to the pointer is the last writer.
    for (int off = NCH - 1; off >= 0; off--) begin
      cand = CW'((int'(ptr) + off) % NCH);
      if (req[cand]) begin
        grant       = '0;
        grant[cand] = 1'b1;
        idx         = cand;
        any         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/phasecalc_arbiter.sv
// Round-robin share of one atan2 engine among NCH valid/ready requesters; one sample in flight,
// result held until out_ready. PHASECALC_TIMEOUT_EN adds a WAIT watchdog that returns angle 0 with out_err.
module phasecalc_arbiter
  import phasecalc_arbiter_pkg::*;
#(
  parameter int  XW             = XW_DEF,
  parameter int  AW             = AW_DEF,
  parameter int  NCH            = 2,
  parameter int  TIMEOUT_CYCLES = 64,
  localparam int CW             = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NCH-1:0]    req_valid,
  output logic [NCH-1:0]    req_ready,
  input  logic [NCH*XW-1:0] req_x,
  input  logic [NCH*XW-1:0] req_y,
  output logic              eng_start,
  output logic [XW-1:0]     eng_x,
  output logic [XW-1:0]     eng_y,
  input  logic              eng_busy,
  input  logic [AW-1:0]     eng_angle,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [AW-1:0]     out_angle,
  output logic [CW-1:0]     out_ch,
  output logic              out_err
);

  state_t         state, state_nx;
  logic [CW-1:0]  rr_ptr, cur_ch, grant_idx;
  logic [NCH-1:0] grant;
  logic           grant_any;
  logic           wd_hit;

  phasecalc_arbiter_rr #(.NCH(NCH), .CW(CW)) u_rr (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (grant_idx),
    .any   (grant_any)
  );

  // Qualified by reset so req_ready stays low while reset is held, even in IDLE.
  assign req_ready = (state == ST_IDLE && reset) ? grant : '0;
  assign eng_start = (state == ST_START);
  assign out_valid = (state == ST_OUT);

`ifdef PHASECALC_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WDW-1:0] wd_cnt;

  assign wd_hit = (state == ST_WAIT) && (wd_cnt == WDW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                 wd_cnt <= '0;
    else if (state != ST_WAIT)  wd_cnt <= '0;
    else if (!wd_hit)           wd_cnt <= wd_cnt + 1'b1;
  end
`else
  assign wd_hit = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (grant_any) state_nx = ST_START;
      ST_START: state_nx = ST_WAIT;
      ST_WAIT:  if (eng_busy || wd_hit) state_nx = ST_OUT;
      ST_OUT:   if (out_ready) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr    <= '0;
      cur_ch    <= '0;
      eng_x     <= '0;
      eng_y     <= '0;
      out_angle <= '0;
      out_ch    <= '0;
      out_err   <= 1'b0;
    end else begin
      if (state == ST_IDLE && grant_any) begin
        cur_ch <= grant_idx;
        eng_x  <= req_x[int'(grant_idx)*XW +: XW];
        eng_y  <= req_y[int'(grant_idx)*XW +: XW];
      end
      if (state == ST_WAIT) begin
        if (eng_busy) begin
          out_angle <= eng_angle;
          out_ch    <= cur_ch;
          out_err   <= 1'b0;
        end else if (wd_hit) begin
          out_angle <= '0;
          out_ch    <= cur_ch;
          out_err   <= 1'b1;
        end
      end
      if (state == ST_OUT && out_ready)
        rr_ptr <= CW'(wrap_inc(int'(cur_ch), NCH));
    end
  end

endmodule
